// File: rtl/uart_alu_ctrl.sv
// Frame sequencer between a UART byte stream and a multi-byte ALU.
// Define UART_ALU_CTRL_TIMEOUT_EN to abort partial frames after TIMEOUT_CYC idle cycles.
module uart_alu_ctrl #(
   parameter int NB_DATA     = 8,
   parameter int NB_OP       = 6,
   parameter int N_BYTES     = 2,
   parameter int ALU_LAT     = 1,
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic                       clk,
   input  logic                       i_rst_n,
   input  logic [NB_DATA-1:0]         i_rx_data,
   input  logic                       i_rx_done,
   output logic [NB_DATA*N_BYTES-1:0] o_data_a,
   output logic [NB_DATA*N_BYTES-1:0] o_data_b,
   output logic [NB_OP-1:0]           o_op,
   output logic                       o_alu_valid,
   input  logic [NB_DATA*N_BYTES-1:0] i_result,
   output logic [NB_DATA-1:0]         o_tx_data,
   output logic                       o_tx_start,
   input  logic                       i_tx_done,
   output logic [3:0]                 o_leds,
   output logic                       o_frame_err,
   output logic                       o_overrun
);

   localparam int W     = NB_DATA * N_BYTES;
   localparam int CNT_W = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
   localparam int LAT_W = $clog2(ALU_LAT + 1);

   localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(N_BYTES - 1);
   localparam logic [LAT_W-1:0] LAT_END   = LAT_W'(ALU_LAT);

   localparam logic [3:0] LED_RX_A = 4'b0001;
   localparam logic [3:0] LED_RX_B = 4'b0010;
   localparam logic [3:0] LED_OP   = 4'b0100;
   localparam logic [3:0] LED_BUSY = 4'b1000;

   typedef enum logic [2:0] {
      S_RX_A,
      S_RX_B,
      S_RX_OP,
      S_EXEC,
      S_TX_LOAD,
      S_TX_WAIT
   } state_t;

   state_t           state;
   logic             rx_done_q;
   logic             tx_done_q;
   logic [CNT_W-1:0] rx_cnt;
   logic [CNT_W-1:0] tx_cnt;
   logic [LAT_W-1:0] lat_cnt;
   logic [W-1:0]     shift;
   logic [W-1:0]     shift_nxt;
   logic             rx_event;
   logic             tx_event;

   // A level held high counts once: only the low-to-high transition is an event.
   assign rx_event  = i_rx_done & ~rx_done_q;
   assign tx_event  = i_tx_done & ~tx_done_q;
   assign shift_nxt = shift >> NB_DATA;

`ifdef UART_ALU_CTRL_TIMEOUT_EN
   localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

   logic [IDLE_W-1:0] idle_cnt;
   logic              partial;
   logic              timeout;

   assign partial = (state == S_RX_B) || (state == S_RX_OP) ||
                    ((state == S_RX_A) && (rx_cnt != '0));
   assign timeout = partial && !rx_event && (idle_cnt == IDLE_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         idle_cnt    <= '0;
         o_frame_err <= 1'b0;
      end else begin
         o_frame_err <= timeout;
         if (rx_event || !partial || timeout) idle_cnt <= '0;
         else                                 idle_cnt <= idle_cnt + 1'b1;
      end
   end
`else
   assign o_frame_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= S_RX_A;
         rx_done_q   <= 1'b0;
         tx_done_q   <= 1'b0;
         rx_cnt      <= '0;
         tx_cnt      <= '0;
         lat_cnt     <= '0;
         shift       <= '0;
         o_data_a    <= '0;
         o_data_b    <= '0;
         o_op        <= '0;
         o_alu_valid <= 1'b0;
         o_tx_data   <= '0;
         o_tx_start  <= 1'b0;
         o_overrun   <= 1'b0;
         o_leds      <= LED_RX_A;
      end else begin
         rx_done_q   <= i_rx_done;
         tx_done_q   <= i_tx_done;
         // NOTE: pulses default low here; a later non-blocking write in the case overrides it.
         o_alu_valid <= 1'b0;
         o_tx_start  <= 1'b0;
         o_overrun   <= 1'b0;
`ifdef UART_ALU_CTRL_TIMEOUT_EN
         if (timeout) begin
            state  <= S_RX_A;
            rx_cnt <= '0;
            o_leds <= LED_RX_A;
         end else
`endif
         case (state)
            S_RX_A: begin
               if (rx_event) begin
                  o_data_a[rx_cnt*NB_DATA +: NB_DATA] <= i_rx_data;
                  if (rx_cnt == LAST_BYTE) begin
                     rx_cnt <= '0;
                     state  <= S_RX_B;
                     o_leds <= LED_RX_B;
                  end else begin
                     rx_cnt <= rx_cnt + 1'b1;
                  end
               end
            end
            S_RX_B: begin
               if (rx_event) begin
                  o_data_b[rx_cnt*NB_DATA +: NB_DATA] <= i_rx_data;
                  if (rx_cnt == LAST_BYTE) begin
                     rx_cnt <= '0;
                     state  <= S_RX_OP;
                     o_leds <= LED_OP;
                  end else begin
                     rx_cnt <= rx_cnt + 1'b1;
                  end
               end
            end
            S_RX_OP: begin
               if (rx_event) begin
                  o_op        <= i_rx_data[NB_OP-1:0];
                  o_alu_valid <= 1'b1;
                  lat_cnt     <= '0;
                  state       <= S_EXEC;
                  o_leds      <= LED_BUSY;
               end
            end
            // The launch cycle plus ALU_LAT more cycles elapse before the result is taken.
            S_EXEC: begin
               o_overrun <= rx_event;
               if (lat_cnt == LAT_END) begin
                  lat_cnt    <= '0;
                  shift      <= i_result;
                  o_tx_data  <= i_result[NB_DATA-1:0];
                  o_tx_start <= 1'b1;
                  tx_cnt     <= '0;
                  state      <= S_TX_LOAD;
               end else begin
                  lat_cnt <= lat_cnt + 1'b1;
               end
            end
            S_TX_LOAD: begin
               o_overrun <= rx_event;
               state     <= S_TX_WAIT;
            end
            S_TX_WAIT: begin
               o_overrun <= rx_event;
               if (tx_event) begin
                  if (tx_cnt == LAST_BYTE) begin
                     tx_cnt <= '0;
                     state  <= S_RX_A;
                     o_leds <= LED_RX_A;
                  end else begin
                     tx_cnt     <= tx_cnt + 1'b1;
                     shift      <= shift_nxt;
                     o_tx_data  <= shift_nxt[NB_DATA-1:0];
                     o_tx_start <= 1'b1;
                     state      <= S_TX_LOAD;
                  end
               end
            end
            default: begin
               state  <= S_RX_A;
               o_leds <= LED_RX_A;
            end
         endcase
      end
   end

endmodule
